// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states,
// owner codes and the all-ones byte-enable used for instruction fetches.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_I    = 2'd1;
  localparam logic [1:0] OWNER_D    = 2'd2;

  // Wide enough for any supported data width; users slice the low DW/8 bits.
  localparam int               BE_MAX      = 32;
  localparam logic [BE_MAX-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT-th enabled cycle (count == TIMEOUT-1).
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  // Count enabled cycles; clear has priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory of the multi-cycle core.
// Data wins by default; after STARVE_MAX consecutive data grants with a
// fetch pending, the fetch is granted. One transaction in flight at a time:
// IDLE (arbitrate) -> BUSY (mem_req high until ack or watchdog) -> DONE
// (one-cycle done pulse to the owner).
// Handshake: requester holds x_req (and its address/data) until its x_done
// pulse; the memory sees mem_req held high with stable mem_* until it
// returns a one-cycle mem_ack, with mem_rdata valid in that same cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int BW = DW / 8;
  localparam int SW = 4;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] starve_cnt;
  logic          grant_i;
  logic          grant_d;
  logic          expire;
  logic          finish;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != ST_BUSY),
    .en     (state == ST_BUSY),
    .expire (expire)
  );

  // Fixed data priority, overridden when the fetch side has been starved.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == ST_IDLE) begin
      grant_d = d_req && !(i_req && (starve_cnt == SW'(STARVE_MAX)));
      grant_i = i_req && !grant_d;
    end
  end

  // An ack in the expiry cycle is still a success.
  assign finish = (state == ST_BUSY) && (mem_ack || expire);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (grant_d || grant_i) state_nx = ST_BUSY;
      ST_BUSY: if (mem_ack || expire)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register; async reset drops mem_req at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Grant capture, starvation counter, result capture and owner tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      owner      <= OWNER_NONE;
      starve_cnt <= '0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        owner     <= OWNER_D;
        if (!i_req)                              starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_MAX))  starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_i) begin
        mem_we     <= 1'b0;
        mem_addr   <= i_addr;
        mem_wdata  <= '0;
        mem_be     <= BE_ALL_ONES[BW-1:0];
        owner      <= OWNER_I;
        starve_cnt <= '0;
      end
      if (finish) begin
        if (owner == OWNER_I) begin
          i_rdata <= mem_ack ? mem_rdata : '0;
          i_err   <= !mem_ack;
        end else begin
          d_rdata <= mem_ack ? mem_rdata : '0;
          d_err   <= !mem_ack;
        end
      end
      if (state == ST_DONE) owner <= OWNER_NONE;
    end
  end

  assign mem_req = (state == ST_BUSY);
  assign i_done  = (state == ST_DONE) && (owner == OWNER_I);
  assign d_done  = (state == ST_DONE) && (owner == OWNER_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset check, a table of single transactions
// with an acking memory model, then simultaneous-request, starvation and
// mid-transaction reset sequences.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          i_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          i_done, i_err, d_done, d_err, mem_req, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [1:0]    owner;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(owner)
  );

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q[$];   // {err, rdata}
  logic [1:0]  own_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
  endtask

  // Vector table
  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    int            delay;     // BUSY cycles before ack; >=16 means never
    logic [DW-1:0] rdata;
    logic          exp_we;
    logic [BW-1:0] exp_be;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;   // cycles from request to done
  } vec_t;

  vec_t vecs[8];

  // Driver: one transaction plus the memory responder.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0;
    int busy = 0;
    logic seen = 1'b0;
    logic [DW:0] e;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      i_req = 1; i_addr = v.addr;
    end
    mem_rdata = v.rdata;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      mem_ack = 0;
      if (i_done || d_done) begin
        seen = 1;
        i_req = 0;
        d_req = 0;
        chk($sformatf("v%0d_done_port", idx), {i_done, d_done}, v.is_d ? 2'b01 : 2'b10);
        chk($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
        chk($sformatf("v%0d_busy_cycles", idx), busy, v.exp_lat - 1);
        e = exp_q.pop_front();
        chk($sformatf("v%0d_rdata", idx), v.is_d ? d_rdata : i_rdata, e[DW-1:0]);
        chk($sformatf("v%0d_err", idx), v.is_d ? d_err : i_err, e[DW]);
      end else if (mem_req) begin
        if (busy == 0) begin
          chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
          chk($sformatf("v%0d_mem_we", idx), mem_we, v.exp_we);
          chk($sformatf("v%0d_mem_be", idx), mem_be, v.exp_be);
          chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
          chk($sformatf("v%0d_owner", idx), owner, v.is_d ? 2'd2 : 2'd1);
        end
        if (busy == v.delay) mem_ack = 1;
        busy++;
      end
    end
    if (!seen) begin
      expire_fail($sformatf("v%0d_done_wait", idx));
      i_req = 0;
      d_req = 0;
      void'(exp_q.pop_front());
    end
  endtask

  // An ack while idle must be ignored.
  task automatic late_ack_check();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      chk("late_ack_no_done", {i_done, d_done, mem_req}, 3'b000);
    end
    chk("late_ack_owner", owner, 2'd0);
  endtask

  initial begin : global_bound
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic        prev_req;
    int          ng;
    logic [1:0]  eo;
    logic [DW:0] e;

    //                is_d we addr        wdata         be    dly rdata         we be    wdata         rdata         err lat
    vecs[0] = '{1'b0, 1'b0, 32'h3000, 32'h0,        4'h0, 3,  32'h8C080004, 1'b0, 4'hF, 32'h0,        32'h8C080004, 1'b0, 5};
    vecs[1] = '{1'b1, 1'b1, 32'h0010, 32'hDEADBEEF, 4'h3, 0,  32'h0,        1'b1, 4'h3, 32'hDEADBEEF, 32'h0,        1'b0, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h0020, 32'h0,        4'hF, 1,  32'hA5A50F0F, 1'b0, 4'hF, 32'h0,        32'hA5A50F0F, 1'b0, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h3004, 32'h0,        4'h0, 7,  32'h24020001, 1'b0, 4'hF, 32'h0,        32'h24020001, 1'b0, 9};
    vecs[4] = '{1'b1, 1'b0, 32'h0040, 32'h0,        4'hF, 99, 32'hFFFFFFFF, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 17};
    vecs[5] = '{1'b0, 1'b0, 32'h3008, 32'h0,        4'h0, 15, 32'h11112222, 1'b0, 4'hF, 32'h0,        32'h11112222, 1'b0, 17};
    vecs[6] = '{1'b0, 1'b0, 32'h300C, 32'h0,        4'h0, 14, 32'h33334444, 1'b0, 4'hF, 32'h0,        32'h33334444, 1'b0, 16};
    vecs[7] = '{1'b1, 1'b1, 32'h0044, 32'h0BADF00D, 4'hC, 2,  32'h0,        1'b1, 4'hC, 32'h0BADF00D, 32'h0,        1'b0, 4};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctrl", {mem_req, i_done, d_done, mem_we, i_err, d_err}, 6'b0);
    chk("reset_owner", owner, 2'd0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_be", mem_be, 4'h0);
    chk("reset_rdata", {i_rdata, d_rdata}, 64'h0);
    rst = 1;

    // Table-driven single transactions
    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], k);
      if (k == 1) chk("i_rdata_hold", i_rdata, vecs[0].exp_rdata);
      if (k == 4) late_ack_check();
    end

    // Simultaneous requests: data first, then fetch
    @(negedge clk);
    i_req = 1; i_addr = 32'h100;
    d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hF;
    own_q = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
    exp_q.push_back({1'b0, 32'hD0D0D0D0});
    exp_q.push_back({1'b0, 32'h10101010});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_ack = 0;
      eo = own_q.pop_front();
      chk($sformatf("sim_owner_c%0d", c + 1), owner, eo);
      if (mem_req) begin
        chk("sim_mem_addr", mem_addr, (owner == 2'd2) ? 32'h200 : 32'h100);
        mem_rdata = (owner == 2'd2) ? 32'hD0D0D0D0 : 32'h10101010;
        mem_ack = 1;
      end
      if (d_done) begin
        d_req = 0;
        e = exp_q.pop_front();
        chk("sim_d_rdata", {d_err, d_rdata}, e);
      end
      if (i_done) begin
        i_req = 0;
        e = exp_q.pop_front();
        chk("sim_i_rdata", {i_err, i_rdata}, e);
      end
    end
    chk("sim_queue_drained", exp_q.size(), 0);
    i_req = 0; d_req = 0; exp_q.delete();

    // Starvation guard: both held continuously
    @(negedge clk);
    i_req = 1; i_addr = 32'h400;
    d_req = 1; d_we = 0; d_addr = 32'h800;
    own_q = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    ng = 0;
    prev_req = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      mem_ack = 0;
      if (mem_req && !prev_req && own_q.size() > 0) begin
        eo = own_q.pop_front();
        chk($sformatf("starve_grant%0d", ng), owner, eo);
        ng++;
      end
      prev_req = mem_req;
      if (mem_req) begin
        mem_rdata = $urandom_range(0, 32'hFFFF);
        mem_ack = 1;
      end
      if ((i_done || d_done) && ng == 10) begin
        i_req = 0;
        d_req = 0;
        break;
      end
    end
    chk("starve_grant_count", ng, 10);
    i_req = 0; d_req = 0;

    // Reset in the middle of a busy transaction
    @(negedge clk);
    i_req = 1; i_addr = 32'h3010; mem_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", mem_req, 1'b1);
    #2 rst = 0;
    #1;
    chk("rst_async_ctrl", {mem_req, i_done, d_done}, 3'b000);
    chk("rst_async_owner", owner, 2'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_regrant_req", mem_req, 1'b1);
    chk("rst_regrant_owner", owner, 2'd1);
    chk("rst_regrant_addr", mem_addr, 32'h3010);
    mem_rdata = 32'hCAFE0001;
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    chk("rst_regrant_done", i_done, 1'b1);
    chk("rst_regrant_rdata", {i_err, i_rdata}, {1'b0, 32'hCAFE0001});
    i_req = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
